// File: rtl/round_robin_request_scheduler.sv
// round_robin_request_scheduler
// Shares one downstream resource among NUM_REQUESTERS requesters. A rotating
// priority pointer picks the first active request at or after it, the grant is
// registered and held until acked or withdrawn, and each completed grant moves
// the pointer past its winner so nobody starves.
module round_robin_request_scheduler #(
   parameter int NUM_REQUESTERS = 8,
   parameter int INDEX_WIDTH    = 3
) (
   input  logic                      clk_in,
   input  logic                      reset_in,
   input  logic [NUM_REQUESTERS-1:0] request_in,
   input  logic                      ack_in,
   output logic                      grant_valid_out,
   output logic [INDEX_WIDTH-1:0]    grant_index_out,
   output logic [NUM_REQUESTERS-1:0] grant_onehot_out,
   output logic [INDEX_WIDTH-1:0]    priority_pointer_out
);

   typedef enum logic {
      IDLE,
      GRANTED
   } state_t;

   // Widened copy of the requester count so index sums can be wrapped without overflow
   localparam logic [INDEX_WIDTH:0]   NUM_WIDE   = (INDEX_WIDTH+1)'(NUM_REQUESTERS);
   localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = INDEX_WIDTH'(NUM_REQUESTERS - 1);

   state_t                      state_q, state_d;
   logic                        valid_q, valid_d;
   logic [INDEX_WIDTH-1:0]      grant_index_q, grant_index_d;
   logic [NUM_REQUESTERS-1:0]   onehot_q, onehot_d;
   logic [INDEX_WIDTH-1:0]      pointer_q, pointer_d;

   logic [NUM_REQUESTERS-1:0]   rotated;
   int                          src_index;
   logic                        found_any;
   logic [INDEX_WIDTH-1:0]      found_index;
   logic [INDEX_WIDTH:0]        winner_sum;
   logic [INDEX_WIDTH-1:0]      winner_index;

   // Rotate requests so the pointer's requester lands at bit 0, then take the lowest set bit
   always_comb begin
      rotated     = '0;
      src_index   = 0;
      found_index = '0;
      for (int i = 0; i < NUM_REQUESTERS; i++) begin
         src_index = i + int'(pointer_q);
         if (src_index >= NUM_REQUESTERS) begin
            src_index = src_index - NUM_REQUESTERS;
         end
         rotated[i] = request_in[src_index];
      end
      found_any = |rotated;
      for (int i = NUM_REQUESTERS - 1; i >= 0; i--) begin
         if (rotated[i]) begin
            found_index = INDEX_WIDTH'(i);
         end
      end
      winner_sum   = {1'b0, found_index} + {1'b0, pointer_q};
      winner_index = (winner_sum >= NUM_WIDE) ? INDEX_WIDTH'(winner_sum - NUM_WIDE)
                                              : INDEX_WIDTH'(winner_sum);
   end

   // Next-state logic: grab a winner when idle, release on ack or withdrawal when granted
   always_comb begin
      state_d       = state_q;
      valid_d       = valid_q;
      grant_index_d = grant_index_q;
      onehot_d      = onehot_q;
      pointer_d     = pointer_q;
      case (state_q)
         IDLE: begin
            if (found_any) begin
               state_d                = GRANTED;
               valid_d                = 1'b1;
               grant_index_d          = winner_index;
               onehot_d               = '0;
               onehot_d[winner_index] = 1'b1;
            end
         end
         GRANTED: begin
            if (ack_in) begin
               pointer_d     = (grant_index_q == LAST_INDEX) ? '0 : grant_index_q + 1'b1;
               state_d       = IDLE;
               valid_d       = 1'b0;
               grant_index_d = '0;
               onehot_d      = '0;
            end else if (!request_in[grant_index_q]) begin
               state_d       = IDLE;
               valid_d       = 1'b0;
               grant_index_d = '0;
               onehot_d      = '0;
            end
         end
         default: begin
            state_d       = IDLE;
            valid_d       = 1'b0;
            grant_index_d = '0;
            onehot_d      = '0;
         end
      endcase
   end

   // State and grant registers; reset wins over any same-cycle ack
   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         state_q       <= IDLE;
         valid_q       <= 1'b0;
         grant_index_q <= '0;
         onehot_q      <= '0;
         pointer_q     <= '0;
      end else begin
         state_q       <= state_d;
         valid_q       <= valid_d;
         grant_index_q <= grant_index_d;
         onehot_q      <= onehot_d;
         pointer_q     <= pointer_d;
      end
   end

   assign grant_valid_out      = valid_q;
   assign grant_index_out      = grant_index_q;
   assign grant_onehot_out     = onehot_q;
   assign priority_pointer_out = pointer_q;

endmodule

// File: tb/tb_round_robin_request_scheduler.sv
// Self-checking bench for round_robin_request_scheduler: directed scenarios
// with fixed expectations plus a randomized run against a behavioural model.
module tb_round_robin_request_scheduler;

   localparam int N  = 8;
   localparam int IW = 3;

   logic          clk_in = 1'b0;
   logic          reset_in;
   logic [N-1:0]  request_in;
   logic          ack_in;
   logic          grant_valid_out;
   logic [IW-1:0] grant_index_out;
   logic [N-1:0]  grant_onehot_out;
   logic [IW-1:0] priority_pointer_out;

   int checks   = 0;
   int failures = 0;

   bit m_valid = 1'b0;
   int m_index = 0;
   int m_ptr   = 0;

   round_robin_request_scheduler #(
      .NUM_REQUESTERS(N),
      .INDEX_WIDTH(IW)
   ) dut (
      .clk_in(clk_in),
      .reset_in(reset_in),
      .request_in(request_in),
      .ack_in(ack_in),
      .grant_valid_out(grant_valid_out),
      .grant_index_out(grant_index_out),
      .grant_onehot_out(grant_onehot_out),
      .priority_pointer_out(priority_pointer_out)
   );

   // Free-running clock
   always #5 clk_in = ~clk_in;

   function automatic logic [N-1:0] model_onehot();
      logic [N-1:0] oh;
      oh = '0;
      if (m_valid) oh[m_index] = 1'b1;
      return oh;
   endfunction

   function automatic logic [14:0] model_vector();
      return {m_valid, IW'(m_index), model_onehot(), IW'(m_ptr)};
   endfunction

   function automatic logic [14:0] dut_vector();
      return {grant_valid_out, grant_index_out, grant_onehot_out, priority_pointer_out};
   endfunction

   // Apply inputs for one clock, advance the model at the edge, settle 1 time unit after it
   task automatic drive(input logic [N-1:0] req, input logic ack, input logic rst);
      request_in = req;
      ack_in     = ack;
      reset_in   = rst;
      @(posedge clk_in);
      if (rst) begin
         m_valid = 1'b0;
         m_index = 0;
         m_ptr   = 0;
      end else if (!m_valid) begin
         for (int k = 0; k < N; k++) begin
            int cand;
            cand = (m_ptr + k) % N;
            if (req[cand]) begin
               m_valid = 1'b1;
               m_index = cand;
               break;
            end
         end
      end else if (ack) begin
         m_ptr   = (m_index + 1) % N;
         m_valid = 1'b0;
         m_index = 0;
      end else if (!req[m_index]) begin
         m_valid = 1'b0;
         m_index = 0;
      end
      #1;
   endtask

   task automatic test_reset();
      drive(8'h00, 1'b0, 1'b1);
      drive(8'h00, 1'b1, 1'b1);
      checks++;
      if ({grant_valid_out, grant_index_out, grant_onehot_out, priority_pointer_out} !== 15'h0) begin
         failures++;
         $display("[TB] FAIL reset_values got=%h want=%h", dut_vector(), 15'h0);
      end
      for (int c = 0; c < 5; c++) begin
         drive(8'h00, 1'b0, 1'b0);
         checks++;
         if (grant_valid_out !== 1'b0 || grant_onehot_out !== 8'h00 || priority_pointer_out !== 3'd0) begin
            failures++;
            $display("[TB] FAIL idle_cycle%0d got valid=%b onehot=%h ptr=%0d want valid=0 onehot=00 ptr=0",
                     c, grant_valid_out, grant_onehot_out, priority_pointer_out);
         end
      end
   endtask

   task automatic test_single_requester();
      logic [N-1:0] hold_req [3];
      hold_req = '{8'h10, 8'hFF, 8'h1F};
      drive(8'h00, 1'b0, 1'b1);
      drive(8'h10, 1'b0, 1'b0);
      checks++;
      if ({grant_valid_out, grant_index_out, grant_onehot_out} !== {1'b1, 3'd4, 8'h10}) begin
         failures++;
         $display("[TB] FAIL single_grant got valid=%b idx=%0d onehot=%h want valid=1 idx=4 onehot=10",
                  grant_valid_out, grant_index_out, grant_onehot_out);
      end
      for (int c = 0; c < 3; c++) begin
         drive(hold_req[c], 1'b0, 1'b0);
         checks++;
         if ({grant_valid_out, grant_index_out, grant_onehot_out, priority_pointer_out} !==
             {1'b1, 3'd4, 8'h10, 3'd0}) begin
            failures++;
            $display("[TB] FAIL single_hold%0d got=%h want=%h", c, dut_vector(), {1'b1, 3'd4, 8'h10, 3'd0});
         end
      end
      drive(8'h00, 1'b1, 1'b0);
      checks++;
      if (grant_valid_out !== 1'b0 || grant_onehot_out !== 8'h00 || priority_pointer_out !== 3'd5) begin
         failures++;
         $display("[TB] FAIL single_ack got valid=%b onehot=%h ptr=%0d want valid=0 onehot=00 ptr=5",
                  grant_valid_out, grant_onehot_out, priority_pointer_out);
      end
      drive(8'h00, 1'b1, 1'b0);
      checks++;
      if (grant_valid_out !== 1'b0 || priority_pointer_out !== 3'd5) begin
         failures++;
         $display("[TB] FAIL idle_ack_ignored got valid=%b ptr=%0d want valid=0 ptr=5",
                  grant_valid_out, priority_pointer_out);
      end
   endtask

   task automatic test_rotation();
      drive(8'h00, 1'b0, 1'b1);
      for (int g = 0; g < 9; g++) begin
         drive(8'hFF, 1'b0, 1'b0);
         checks++;
         if (grant_valid_out !== 1'b1 || grant_index_out !== IW'(g % N)) begin
            failures++;
            $display("[TB] FAIL rotation_grant%0d got valid=%b idx=%0d want valid=1 idx=%0d",
                     g, grant_valid_out, grant_index_out, g % N);
         end
         drive(8'hFF, 1'b1, 1'b0);
         checks++;
         if (grant_valid_out !== 1'b0 || priority_pointer_out !== IW'((g + 1) % N)) begin
            failures++;
            $display("[TB] FAIL rotation_release%0d got valid=%b ptr=%0d want valid=0 ptr=%0d",
                     g, grant_valid_out, priority_pointer_out, (g + 1) % N);
         end
      end
   endtask

   task automatic test_wrap_around();
      drive(8'h00, 1'b0, 1'b1);
      drive(8'h20, 1'b0, 1'b0);
      drive(8'h20, 1'b1, 1'b0);
      checks++;
      if (priority_pointer_out !== 3'd6) begin
         failures++;
         $display("[TB] FAIL wrap_setup_ptr got=%0d want=6", priority_pointer_out);
      end
      drive(8'h05, 1'b0, 1'b0);
      checks++;
      if ({grant_valid_out, grant_index_out, grant_onehot_out} !== {1'b1, 3'd0, 8'h01}) begin
         failures++;
         $display("[TB] FAIL wrap_grant got valid=%b idx=%0d onehot=%h want valid=1 idx=0 onehot=01",
                  grant_valid_out, grant_index_out, grant_onehot_out);
      end
      drive(8'h05, 1'b1, 1'b0);
      checks++;
      if (grant_valid_out !== 1'b0 || priority_pointer_out !== 3'd1) begin
         failures++;
         $display("[TB] FAIL wrap_ack got valid=%b ptr=%0d want valid=0 ptr=1",
                  grant_valid_out, priority_pointer_out);
      end
      drive(8'h05, 1'b0, 1'b0);
      checks++;
      if (grant_valid_out !== 1'b1 || grant_index_out !== 3'd2) begin
         failures++;
         $display("[TB] FAIL wrap_next_grant got valid=%b idx=%0d want valid=1 idx=2",
                  grant_valid_out, grant_index_out);
      end
   endtask

   task automatic test_withdrawal();
      drive(8'h00, 1'b0, 1'b1);
      drive(8'h04, 1'b0, 1'b0);
      drive(8'h04, 1'b1, 1'b0);
      drive(8'h08, 1'b0, 1'b0);
      checks++;
      if (grant_valid_out !== 1'b1 || grant_index_out !== 3'd3 || priority_pointer_out !== 3'd3) begin
         failures++;
         $display("[TB] FAIL withdraw_setup got valid=%b idx=%0d ptr=%0d want valid=1 idx=3 ptr=3",
                  grant_valid_out, grant_index_out, priority_pointer_out);
      end
      drive(8'h00, 1'b0, 1'b0);
      checks++;
      if (grant_valid_out !== 1'b0 || grant_onehot_out !== 8'h00 || priority_pointer_out !== 3'd3) begin
         failures++;
         $display("[TB] FAIL withdraw_release got valid=%b onehot=%h ptr=%0d want valid=0 onehot=00 ptr=3",
                  grant_valid_out, grant_onehot_out, priority_pointer_out);
      end
      drive(8'h08, 1'b0, 1'b0);
      drive(8'h00, 1'b1, 1'b0);
      checks++;
      if (grant_valid_out !== 1'b0 || priority_pointer_out !== 3'd4) begin
         failures++;
         $display("[TB] FAIL ack_and_withdraw got valid=%b ptr=%0d want valid=0 ptr=4",
                  grant_valid_out, priority_pointer_out);
      end
   endtask

   task automatic test_reset_mid_grant();
      drive(8'h00, 1'b0, 1'b1);
      drive(8'h20, 1'b0, 1'b0);
      drive(8'h20, 1'b1, 1'b1);
      checks++;
      if (dut_vector() !== 15'h0) begin
         failures++;
         $display("[TB] FAIL reset_mid_grant got=%h want=%h", dut_vector(), 15'h0);
      end
      drive(8'h02, 1'b0, 1'b0);
      checks++;
      if (grant_valid_out !== 1'b1 || grant_index_out !== 3'd1) begin
         failures++;
         $display("[TB] FAIL after_reset_grant got valid=%b idx=%0d want valid=1 idx=1",
                  grant_valid_out, grant_index_out);
      end
   endtask

   task automatic test_random();
      logic [N-1:0] req;
      drive(8'h00, 1'b0, 1'b1);
      req = '0;
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(0, 2) == 0) req = N'($urandom & $urandom);
         drive(req, ($urandom_range(0, 2) == 0), ($urandom_range(0, 63) == 0));
         checks++;
         if (dut_vector() !== model_vector()) begin
            failures++;
            $display("[TB] FAIL random_cycle%0d got {v,idx,oh,ptr}=%h want=%h", c, dut_vector(), model_vector());
         end
      end
   endtask

   // Run all scenarios in sequence, then report
   initial begin
      request_in = '0;
      ack_in     = 1'b0;
      reset_in   = 1'b1;
      test_reset();
      test_single_requester();
      test_rotation();
      test_wrap_around();
      test_withdrawal();
      test_reset_mid_grant();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/round_robin_request_scheduler.md
# round_robin_request_scheduler

- Shares one downstream resource (e.g. a cache port or writeback channel) among `NUM_REQUESTERS` requesters.
- Uses rotating-priority selection built on the team's first-one search.
- Issues one registered grant at a time and holds it until the resource acknowledges it or the requester withdraws.
- After each completed grant, priority advances past the winner, so no requester starves.

## Interface
Parameters:
- `NUM_REQUESTERS`, 8, number of request lines; must be ≥ 2.
- `INDEX_WIDTH`, 3, width of the grant index; must equal `$clog2(NUM_REQUESTERS)`.

Ports:
- `clk_in`  input  1  single clock; all state changes on its rising edge.
- `reset_in`  input  1  synchronous, active-high reset.
- `request_in`  input  `NUM_REQUESTERS`  level request per requester; must stay high until acked.
- `ack_in`  input  1  downstream accepted the current grant; only meaningful while `grant_valid_out`=1.
- `grant_valid_out`  output  1  a grant is active.
- `grant_index_out`  output  `INDEX_WIDTH`  index of the granted requester.
- `grant_onehot_out`  output  `NUM_REQUESTERS`  one-hot form of the grant; all zero when no grant is active.
- `priority_pointer_out`  output  `INDEX_WIDTH`  index holding highest priority next arbitration (debug/verification).

## Operation
State machine has two states, IDLE and GRANTED.

IDLE:
- Rotate `request_in` right by `priority_pointer`, then find the first one (lowest index).
- Winner = (found index + pointer) mod `NUM_REQUESTERS`.
- If any request is set: register the winner into `grant_index_out`, set `grant_valid_out` and the `grant_onehot_out` bit, go to GRANTED.
- If no request is set: stay in IDLE; outputs stay zero.

GRANTED:
- Grant outputs are frozen; requests from other requesters are ignored.
- If `ack_in`=1: pointer ← (granted index + 1) mod `NUM_REQUESTERS`, wrapping from `NUM_REQUESTERS`-1 to 0. Clear the grant, go to IDLE.
- Else if `request_in[grant_index]`=0 (withdrawal): clear the grant, go to IDLE, pointer unchanged.
- `ack_in` and withdrawal in the same cycle: ack wins (completed grant, pointer advances).
- `ack_in` while in IDLE is ignored.

Pointer and index arithmetic:
- Mod-`NUM_REQUESTERS` arithmetic in `INDEX_WIDTH` bits.
- For non-power-of-two N, explicit compare-and-wrap; the pointer never holds a value ≥ `NUM_REQUESTERS`.

## Timing
- Reset values: state IDLE, `grant_valid_out`=0, `grant_index_out`=0, `grant_onehot_out`=0, `priority_pointer_out`=0.
- Reset asserted mid-grant clears everything at the next edge, regardless of `ack_in`.
- Grant latency:
  - Request sampled at edge t in IDLE → `grant_valid_out`=1 after edge t (visible cycle t+1).
  - All grant outputs come straight from registers; no combinational path from inputs to outputs.
- Release:
  - `ack_in`=1 sampled at edge t → `grant_valid_out`=0 and pointer updated after edge t.
  - The earliest next grant follows the edge after that, i.e. one idle cycle between grants.
  - Maximum throughput is one grant per 2 cycles.
- A grant with the same-cycle requests snapshot is never re-evaluated while GRANTED.

## Test plan
- Reset then idle: hold `request_in`=8'h00 for 5 cycles after reset → `grant_valid_out`=0, `grant_onehot_out`=0, pointer=0 throughout.
- Single requester:
  - `request_in`=8'h10 → next cycle `grant_valid_out`=1, `grant_index_out`=4, `grant_onehot_out`=8'h10.
  - Hold 3 cycles without ack → outputs unchanged.
  - Ack → grant drops the next cycle, pointer=5.
- Rotation fairness:
  - `request_in`=8'hFF held, ack every grant → grant sequence 0,1,2,…,7,0, one grant every 2 cycles.
  - Pointer wraps 7→0.
- Wrap-around selection: pointer=6 (reached via prior acks), `request_in`=8'h05 → grant index 0; after ack, pointer=1, next grant index 2.
- Withdrawal and simultaneous events:
  - Grant index 3; drop `request_in[3]` without ack → grant clears, pointer stays 3.
  - Repeat with ack and drop in the same cycle → pointer=4.
- Reset mid-operation: grant active on index 5, assert `reset_in` for 1 cycle together with `ack_in` → all outputs 0, pointer=0, state IDLE.
